extinguisher_driver: RTL

- Responder side of the fire-alarm extinguish request in the smart-store safety path.
- The alarm block raises a level `extinguish_req`. This block sequences the physical response:
  - an evacuation-warning pre-delay, then
  - timed spray bursts with pauses between them,
  - with water-flow verification on every burst.
- It returns `ack` when the sequence completes and latches a sticky `fault` when flow is missing.
- Sits between the alarm module and the valve/buzzer actuators.

---
 rtl/extinguisher_driver_pkg.sv | 32 +++
 rtl/extinguisher_driver_down_timer.sv | 34 +++
 rtl/extinguisher_driver.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/extinguisher_driver_pkg.sv
`default_nettype none
// ============================================================================
// extinguisher_driver_pkg : state encodings, default timing, timer sizing
// Rev 1.0
// ============================================================================
package extinguisher_driver_pkg;

    localparam int DEF_ARM_CYCLES   = 4;
    localparam int DEF_SPRAY_CYCLES = 8;
    localparam int DEF_PAUSE_CYCLES = 4;
    localparam int DEF_FLOW_TIMEOUT = 3;
    localparam int DEF_MAX_BURSTS   = 3;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_SPRAY = 3'd2,
        S_PAUSE = 3'd3,
        S_DONE  = 3'd4,
        S_FAULT = 3'd5
    } state_t;

    // Timer only ever holds (cycles - 1), so clog2 of the largest period suffices.
    function automatic int timer_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/extinguisher_driver_down_timer.sv
`default_nettype none
// ============================================================================
// down_timer : loadable down-counter that saturates at zero
// Rev 1.0
// ============================================================================
module down_timer #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             zero,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (en && (count_q != '0)) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    assign zero  = (count_q == '0);
    assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/extinguisher_driver.sv
`default_nettype none
// ============================================================================
// extinguisher_driver : warn / spray / pause sequencer with flow supervision
// Rev 1.0
// ============================================================================
module extinguisher_driver
    import extinguisher_driver_pkg::*;
#(
    parameter int ARM_CYCLES   = DEF_ARM_CYCLES,
    parameter int SPRAY_CYCLES = DEF_SPRAY_CYCLES,
    parameter int PAUSE_CYCLES = DEF_PAUSE_CYCLES,
    parameter int FLOW_TIMEOUT = DEF_FLOW_TIMEOUT,
    parameter int MAX_BURSTS   = DEF_MAX_BURSTS
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            extinguish_req,
    input  logic                            flow_ok,
    input  logic                            manual_stop,
    output logic                            warn,
    output logic                            valve_open,
    output logic                            ack,
    output logic                            fault,
    output logic [$clog2(MAX_BURSTS+1)-1:0] burst_count
);

    localparam int TW = timer_width(ARM_CYCLES, SPRAY_CYCLES, PAUSE_CYCLES);
    localparam int BW = $clog2(MAX_BURSTS + 1);

    localparam logic [TW-1:0] ARM_LOAD   = TW'(ARM_CYCLES - 1);
    localparam logic [TW-1:0] SPRAY_LOAD = TW'(SPRAY_CYCLES - 1);
    localparam logic [TW-1:0] PAUSE_LOAD = TW'(PAUSE_CYCLES - 1);
    // Timer value seen on the FLOW_TIMEOUT-th cycle of a burst.
    localparam logic [TW-1:0] FLOW_CHK   = TW'(SPRAY_CYCLES - FLOW_TIMEOUT);

    state_t          state_q, state_d;
    logic [BW-1:0]   burst_q, burst_d, burst_inc;
    logic            flow_seen_q, flow_seen_d;
    logic            warn_q, valve_q, ack_q, fault_q;

    logic            tmr_load, tmr_en, tmr_zero;
    logic [TW-1:0]   tmr_load_val, tmr_count;
    logic            flow_timeout;

    down_timer #(.WIDTH(TW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .en       (tmr_en),
        .zero     (tmr_zero),
        .count    (tmr_count)
    );

    assign burst_inc    = burst_q + BW'(1);
    assign flow_timeout = (state_q == S_SPRAY) && !flow_seen_q && !flow_ok
                          && (tmr_count == FLOW_CHK);

    always_comb begin
        state_d      = state_q;
        burst_d      = burst_q;
        flow_seen_d  = flow_seen_q;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        tmr_en       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (extinguish_req) begin
                    state_d      = S_ARM;
                    tmr_load     = 1'b1;
                    tmr_load_val = ARM_LOAD;
                    burst_d      = '0;
                end
            end
            S_ARM: begin
                if (manual_stop || !extinguish_req) begin
                    state_d = S_IDLE;
                end else if (tmr_zero) begin
                    state_d      = S_SPRAY;
                    tmr_load     = 1'b1;
                    tmr_load_val = SPRAY_LOAD;
                    flow_seen_d  = 1'b0;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            S_SPRAY: begin
                flow_seen_d = flow_seen_q | flow_ok;
                if (flow_timeout) begin
                    state_d = S_FAULT;
                end else if (manual_stop) begin
                    state_d = S_DONE;
                end else if (tmr_zero) begin
                    burst_d = burst_inc;
                    // A request drop mid-burst only suppresses the next burst.
                    if ((burst_inc == BW'(MAX_BURSTS)) || !extinguish_req) begin
                        state_d = S_DONE;
                    end else begin
                        state_d      = S_PAUSE;
                        tmr_load     = 1'b1;
                        tmr_load_val = PAUSE_LOAD;
                    end
                end else begin
                    tmr_en = 1'b1;
                end
            end
            S_PAUSE: begin
                if (manual_stop) begin
                    state_d = S_DONE;
                end else if (tmr_zero) begin
                    if (extinguish_req) begin
                        state_d      = S_SPRAY;
                        tmr_load     = 1'b1;
                        tmr_load_val = SPRAY_LOAD;
                        flow_seen_d  = 1'b0;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    tmr_en = 1'b1;
                end
            end
            S_DONE: begin
                if (!extinguish_req) begin
                    state_d = S_IDLE;
                end
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            burst_q     <= '0;
            flow_seen_q <= 1'b0;
            warn_q      <= 1'b0;
            valve_q     <= 1'b0;
            ack_q       <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            burst_q     <= burst_d;
            flow_seen_q <= flow_seen_d;
            // Outputs registered from next state, so they track state_q exactly.
            warn_q      <= (state_d == S_ARM) || (state_d == S_SPRAY) ||
                           (state_d == S_PAUSE) || (state_d == S_FAULT);
            valve_q     <= (state_d == S_SPRAY);
            ack_q       <= (state_d == S_DONE);
            fault_q     <= (state_d == S_FAULT);
        end
    end

    assign warn        = warn_q;
    assign valve_open  = valve_q;
    assign ack         = ack_q;
    assign fault       = fault_q;
    assign burst_count = burst_q;

endmodule
`default_nettype wire
